// File: rtl/r2sdf_bf_if.sv
// Streaming sample bus for the R2SDF butterfly stage: input samples with frame sync, output sums/differences.
// Output width is WIDTH+1, or WIDTH when R2SDF_SCALE_EN is defined.
interface r2sdf_bf_if #(
  parameter int WIDTH = 16
);
`ifdef R2SDF_SCALE_EN
  localparam int OW = WIDTH;
`else
  localparam int OW = WIDTH + 1;
`endif

  logic                    valid_i;
  logic                    sync_i;
  logic signed [WIDTH-1:0] data_in_r;
  logic signed [WIDTH-1:0] data_in_i;
  logic                    valid_o;
  logic signed [OW-1:0]    data_out_r;
  logic signed [OW-1:0]    data_out_i;

  modport master (
    output valid_i, sync_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i
  );

  modport slave (
    input  valid_i, sync_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i
  );
endinterface

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage; one complex sample per accepted cycle.
// Define R2SDF_SCALE_EN to round-halve and saturate the output to WIDTH bits.
module r2sdf_bf_stage #(
  parameter int WIDTH = 16,
  parameter int DELAY = 16
) (
  input logic       clk,
  input logic       rst_n,
  r2sdf_bf_if.slave bus
);
  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(2 * DELAY);
`ifdef R2SDF_SCALE_EN
  localparam int OW = WIDTH;
  localparam logic signed [EW:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};
`else
  localparam int OW = WIDTH + 1;
`endif

  logic [CW-1:0]          cnt;
  logic                   primed;
  logic signed [EW-1:0]   dly_r [DELAY];
  logic signed [EW-1:0]   dly_i [DELAY];

  logic signed [EW-1:0]   x_r_p0, x_i_p0;
  logic signed [EW-1:0]   d_r_p0, d_i_p0;
  logic signed [EW-1:0]   sum_r_p0, sum_i_p0;
  logic signed [EW-1:0]   dif_r_p0, dif_i_p0;
  logic signed [EW-1:0]   push_r_p0, push_i_p0;
  logic signed [EW-1:0]   res_r_p0, res_i_p0;
  logic                   bfly_p0;

  logic                   vld_p1;
  logic signed [OW-1:0]   out_r_p1, out_i_p1;

  function automatic logic signed [OW-1:0] fmt(input logic signed [EW-1:0] v);
`ifdef R2SDF_SCALE_EN
    logic signed [EW:0] t;
    t = $signed({v[EW-1], v}) + $signed((EW+1)'(1));
    t = t >>> 1;
    if (t > SAT_MAX)      return SAT_MAX[OW-1:0];
    else if (t < SAT_MIN) return SAT_MIN[OW-1:0];
    else                  return t[OW-1:0];
`else
    return v;
`endif
  endfunction

  // Stage p0: butterfly against the oldest delay-line entry
  assign x_r_p0  = {bus.data_in_r[WIDTH-1], bus.data_in_r};
  assign x_i_p0  = {bus.data_in_i[WIDTH-1], bus.data_in_i};
  assign d_r_p0  = dly_r[DELAY-1];
  assign d_i_p0  = dly_i[DELAY-1];
  // A sync sample is always treated as index 0, i.e. a fill sample
  assign bfly_p0 = cnt[CW-1] & ~bus.sync_i;

  always_comb begin
    sum_r_p0  = d_r_p0 + x_r_p0;
    sum_i_p0  = d_i_p0 + x_i_p0;
    dif_r_p0  = d_r_p0 - x_r_p0;
    dif_i_p0  = d_i_p0 - x_i_p0;
    push_r_p0 = bfly_p0 ? dif_r_p0 : x_r_p0;
    push_i_p0 = bfly_p0 ? dif_i_p0 : x_i_p0;
    res_r_p0  = bfly_p0 ? sum_r_p0 : d_r_p0;
    res_i_p0  = bfly_p0 ? sum_i_p0 : d_i_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      primed <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (!bus.valid_i) begin
      vld_p1 <= 1'b0;
    end else if (bus.sync_i) begin
      cnt    <= CW'(1);
      primed <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      cnt    <= cnt + CW'(1);
      vld_p1 <= cnt[CW-1] ? 1'b1 : primed;
      if (&cnt)
        primed <= 1'b1;
    end
  end

  // Stage p1: delay-line shift and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY; k++) begin
        dly_r[k] <= '0;
        dly_i[k] <= '0;
      end
      out_r_p1 <= '0;
      out_i_p1 <= '0;
    end else if (bus.valid_i) begin
      dly_r[0] <= push_r_p0;
      dly_i[0] <= push_i_p0;
      for (int k = 1; k < DELAY; k++) begin
        dly_r[k] <= dly_r[k-1];
        dly_i[k] <= dly_i[k-1];
      end
      out_r_p1 <= fmt(res_r_p0);
      out_i_p1 <= fmt(res_i_p0);
    end
  end

  assign bus.valid_o    = vld_p1;
  assign bus.data_out_r = out_r_p1;
  assign bus.data_out_i = out_i_p1;
endmodule
